fifo_rd_stream: RTL and testbench

Read-side drain engine for the dual-clock FIFO. It sits entirely in the read clock domain. It issues `rdreq` against the FIFO read port (`rd_empty`, registered `data_out` with fixed read latency) and repacks returned words into a registered valid/ready stream. A small credit-tracked output buffer gives full throughput (one word per cycle) under no backpressure and guarantees no word is lost or duplicated when the downstream consumer stalls.

---
 rtl/fifo_rd_stream_if.sv | 29 ++
 rtl/fifo_rd_stream.sv | 86 ++++++++
 tb/tb_fifo_rd_stream.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_rd_stream_if.sv
// FIFO read port plus registered valid/ready output stream for the read-side drain engine.
interface fifo_rd_stream_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  rd_empty;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  rdreq;
    logic                  m_valid;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_ready;

    modport master (
        input  rd_empty,
        input  data_out,
        output rdreq,
        output m_valid,
        output m_data,
        input  m_ready
    );

    modport slave (
        output rd_empty,
        output data_out,
        input  rdreq,
        input  m_valid,
        input  m_data,
        output m_ready
    );
endinterface

// File: rtl/fifo_rd_stream.sv
// Read-side drain engine: issues FIFO reads against a credit-tracked output buffer
// and presents the returned words as a valid/ready stream, in order and exactly once.
module fifo_rd_stream #(
    parameter int DATA_WIDTH   = 8,
    parameter int READ_LATENCY = 1,
    parameter int BUF_DEPTH    = 2,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    fifo_rd_stream_if.master     bus,
    output logic [CNT_WIDTH-1:0] xfer_cnt
);
    localparam int OCC_W = $clog2(BUF_DEPTH + 1);
    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CRD_W = OCC_W + 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BUF_DEPTH - 1);
    localparam logic [CRD_W-1:0] DEPTH_C  = CRD_W'(BUF_DEPTH);

    logic [DATA_WIDTH-1:0]   buf_mem [BUF_DEPTH];
    logic [PTR_W-1:0]        head;
    logic [PTR_W-1:0]        tail;
    logic [OCC_W-1:0]        occ;
    logic [READ_LATENCY-1:0] infl;
    logic [OCC_W-1:0]        inflight;
    logic [CRD_W-1:0]        credit_used;
    logic                    pop;
    logic                    issue;
    logic                    ret;

    assign pop   = bus.m_valid & bus.m_ready;
    assign issue = bus.rdreq;
    assign ret   = infl[READ_LATENCY-1];

    always_comb begin
        inflight = '0;
        for (int unsigned i = 0; i < READ_LATENCY; i++) begin
            inflight = inflight + OCC_W'(infl[i]);
        end
    end

    // A pop this cycle frees its slot before the next edge, so it counts as a credit now.
    always_comb begin
        credit_used = CRD_W'(occ) + CRD_W'(inflight) - CRD_W'(pop);
    end

    assign bus.rdreq   = ~rst & ~bus.rd_empty & (credit_used < DEPTH_C);
    assign bus.m_valid = (occ != '0);
    assign bus.m_data  = buf_mem[head];

    generate
        if (READ_LATENCY == 1) begin : g_infl_single
            always_ff @(posedge clk or posedge rst) begin
                if (rst) infl <= '0;
                else     infl <= issue;
            end
        end else begin : g_infl_shift
            always_ff @(posedge clk or posedge rst) begin
                if (rst) infl <= '0;
                else     infl <= {infl[READ_LATENCY-2:0], issue};
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head     <= '0;
            tail     <= '0;
            occ      <= '0;
            xfer_cnt <= '0;
            for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
                buf_mem[i] <= '0;
            end
        end else begin
            if (ret) begin
                buf_mem[tail] <= bus.data_out;
                tail          <= (tail == LAST_PTR) ? '0 : tail + 1'b1;
            end
            if (pop) begin
                head     <= (head == LAST_PTR) ? '0 : head + 1'b1;
                xfer_cnt <= xfer_cnt + 1'b1;
            end
            occ <= occ + OCC_W'(ret) - OCC_W'(pop);
        end
    end
endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: latency-1/depth-2 and latency-3/depth-4 instances driven from
// behavioural FIFO read-port models, with cycle tables, scenario tables and an order scoreboard.
module tb_fifo_rd_stream;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fifo_rd_stream_if #(.DATA_WIDTH(8)) if_a ();
    fifo_rd_stream_if #(.DATA_WIDTH(8)) if_b ();
    logic [15:0] cnt_a;
    logic [15:0] cnt_b;

    fifo_rd_stream #(.DATA_WIDTH(8), .READ_LATENCY(1), .BUF_DEPTH(2), .CNT_WIDTH(16)) dut_a (
        .clk(clk), .rst(rst), .bus(if_a.master), .xfer_cnt(cnt_a));
    fifo_rd_stream #(.DATA_WIDTH(8), .READ_LATENCY(3), .BUF_DEPTH(4), .CNT_WIDTH(16)) dut_b (
        .clk(clk), .rst(rst), .bus(if_b.master), .xfer_cnt(cnt_b));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // FIFO read-port models
    logic [7:0] mem_a [256];
    logic [7:0] mem_b [256];
    int wr_a = 0, rd_a = 0, wr_b = 0, rd_b = 0;
    logic fe_a = 1'b0;
    logic [7:0] dq_a = '0;
    logic [7:0] p1_b = '0, p2_b = '0, dq_b = '0;

    assign if_a.rd_empty = (rd_a == wr_a) || fe_a;
    assign if_b.rd_empty = (rd_b == wr_b);
    assign if_a.data_out = dq_a;
    assign if_b.data_out = dq_b;

    always @(posedge clk) begin
        if (!rst && if_a.rdreq) begin
            dq_a <= mem_a[rd_a[7:0]];
            rd_a <= rd_a + 1;
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            rd_b <= wr_b;
            p1_b <= '0;
            p2_b <= '0;
            dq_b <= '0;
        end else begin
            if (if_b.rdreq) begin
                p1_b <= mem_b[rd_b[7:0]];
                rd_b <= rd_b + 1;
            end
            p2_b <= p1_b;
            dq_b <= p2_b;
        end
    end

    // Scoreboards: order, no read while empty, outstanding words within buffer depth
    int exp_a = 0, iss_a = 0, pop_a = 0;
    int exp_b = 0, iss_b = 0, pop_b = 0;

    always @(negedge clk) begin
        if (!rst) begin
            chk("a_rdreq_while_empty", 32'(if_a.rdreq & if_a.rd_empty), 32'd0);
            chk("a_outstanding", (iss_a - pop_a > 2) ? 32'(iss_a - pop_a) : 32'd0, 32'd0);
            if (if_a.rdreq) iss_a <= iss_a + 1;
            if (if_a.m_valid && if_a.m_ready) begin
                chk("a_order", 32'(if_a.m_data), 32'(mem_a[exp_a[7:0]]));
                exp_a <= exp_a + 1;
                pop_a <= pop_a + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            iss_b <= 0;
            pop_b <= 0;
            exp_b <= wr_b;
        end else begin
            chk("b_rdreq_while_empty", 32'(if_b.rdreq & if_b.rd_empty), 32'd0);
            chk("b_outstanding", (iss_b - pop_b > 4) ? 32'(iss_b - pop_b) : 32'd0, 32'd0);
            if (if_b.rdreq) iss_b <= iss_b + 1;
            if (if_b.m_valid && if_b.m_ready) begin
                chk("b_order", 32'(if_b.m_data), 32'(mem_b[exp_b[7:0]]));
                exp_b <= exp_b + 1;
                pop_b <= pop_b + 1;
            end
        end
    end

    typedef struct {
        logic        push;
        logic [7:0]  pdata;
        logic        m_ready;
        logic        rdreq;
        logic        valid;
        logic [7:0]  data;
        logic [15:0] cnt;
    } vec_t;

    typedef struct {
        int          n;
        logic [7:0]  base;
        int          stall_len;
        int          empty_from;
        int          empty_len;
        int          exp_stall_reads;
        int          exp_span;
        int          exp_vcycles;
        logic [15:0] exp_cnt;
    } scen_t;

    vec_t  vecs [12];
    scen_t scens [3];

    task automatic run_a(input scen_t s, input int idx);
        int delivered = 0;
        int stall_reads = 0;
        int first_v = -1;
        int last_v = -1;
        int vcyc = 0;
        for (int k = 0; k < s.n; k++) begin
            mem_a[wr_a[7:0]] = s.base + 8'(k);
            wr_a = wr_a + 1;
        end
        for (int c = 0; c < 200 && delivered < s.n; c++) begin
            if_a.m_ready = (c >= s.stall_len);
            fe_a = (c >= s.empty_from) && (c < s.empty_from + s.empty_len);
            @(negedge clk);
            if (c < s.stall_len && if_a.rdreq) stall_reads++;
            if (c == s.stall_len - 1) begin
                chk($sformatf("s%0d_stall_valid", idx), 32'(if_a.m_valid), 32'd1);
                chk($sformatf("s%0d_stall_data", idx), 32'(if_a.m_data), 32'(s.base));
            end
            if (if_a.m_valid) begin
                if (first_v < 0) first_v = c;
                last_v = c;
                vcyc++;
            end
            if (if_a.m_valid && if_a.m_ready) delivered++;
            @(posedge clk);
            #1;
        end
        fe_a = 1'b0;
        if_a.m_ready = 1'b1;
        chk($sformatf("s%0d_delivered", idx), 32'(delivered), 32'(s.n));
        chk($sformatf("s%0d_stall_reads", idx), 32'(stall_reads), 32'(s.exp_stall_reads));
        chk($sformatf("s%0d_valid_span", idx), 32'(last_v - first_v + 1), 32'(s.exp_span));
        chk($sformatf("s%0d_valid_cycles", idx), 32'(vcyc), 32'(s.exp_vcycles));
        chk($sformatf("s%0d_xfer_cnt", idx), 32'(cnt_a), 32'(s.exp_cnt));
    endtask

    initial begin
        int delivered_b;

        //            push pdata  rdy  rdreq vld data   cnt
        vecs[0]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 16'd0};
        vecs[1]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 16'd0};
        vecs[2]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hA5, 16'd0};
        vecs[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 16'd1};
        vecs[4]  = '{1'b1, 8'hB0, 1'b0, 1'b1, 1'b0, 8'h00, 16'd1};
        vecs[5]  = '{1'b1, 8'hB1, 1'b0, 1'b1, 1'b0, 8'h00, 16'd1};
        vecs[6]  = '{1'b1, 8'hB2, 1'b0, 1'b0, 1'b1, 8'hB0, 16'd1};
        vecs[7]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hB0, 16'd1};
        vecs[8]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hB0, 16'd1};
        vecs[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hB1, 16'd2};
        vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hB2, 16'd3};
        vecs[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'hB1, 16'd4};

        //           n   base   stall ef el reads span vcyc cnt
        scens[0] = '{16, 8'h00, 0,    0, 0, 0,    16,  16,  16'd20};
        scens[1] = '{8,  8'h00, 10,   0, 0, 2,    16,  16,  16'd28};
        scens[2] = '{10, 8'h40, 0,    4, 3, 0,    13,  10,  16'd38};

        if_a.m_ready = 1'b1;
        if_b.m_ready = 1'b1;
        mem_a[0] = 8'hA5;
        wr_a = 1;

        // Reset held with data available and the consumer ready
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_a_rdreq", 32'(if_a.rdreq), 32'd0);
        chk("rst_a_valid", 32'(if_a.m_valid), 32'd0);
        chk("rst_a_data", 32'(if_a.m_data), 32'd0);
        chk("rst_a_cnt", 32'(cnt_a), 32'd0);
        chk("rst_b_rdreq", 32'(if_b.rdreq), 32'd0);
        chk("rst_b_valid", 32'(if_b.m_valid), 32'd0);
        chk("rst_b_data", 32'(if_b.m_data), 32'd0);
        chk("rst_b_cnt", 32'(cnt_b), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single word then short backpressure, cycle by cycle
        for (int i = 0; i < 12; i++) begin
            if (vecs[i].push) begin
                mem_a[wr_a[7:0]] = vecs[i].pdata;
                wr_a = wr_a + 1;
            end
            if_a.m_ready = vecs[i].m_ready;
            @(negedge clk);
            chk($sformatf("v%0d_rdreq", i), 32'(if_a.rdreq), 32'(vecs[i].rdreq));
            chk($sformatf("v%0d_valid", i), 32'(if_a.m_valid), 32'(vecs[i].valid));
            chk($sformatf("v%0d_data", i), 32'(if_a.m_data), 32'(vecs[i].data));
            chk($sformatf("v%0d_cnt", i), 32'(cnt_a), 32'(vecs[i].cnt));
            @(posedge clk);
            #1;
        end
        if_a.m_ready = 1'b1;

        // Streaming, backpressure, empty mid-stream
        for (int i = 0; i < 3; i++) begin
            run_a(scens[i], i);
        end

        // Latency 3 / depth 4 with random consumer
        for (int k = 0; k < 20; k++) begin
            mem_b[wr_b[7:0]] = 8'h80 + 8'(k);
            wr_b = wr_b + 1;
        end
        delivered_b = 0;
        for (int c = 0; c < 400 && delivered_b < 20; c++) begin
            if_b.m_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (if_b.m_valid && if_b.m_ready) delivered_b++;
            @(posedge clk);
            #1;
        end
        if_b.m_ready = 1'b1;
        chk("b_delivered", 32'(delivered_b), 32'd20);
        chk("b_xfer_cnt", 32'(cnt_b), 32'd20);

        // Reset in the middle of a burst
        for (int k = 0; k < 20; k++) begin
            mem_b[wr_b[7:0]] = 8'hA0 + 8'(k);
            wr_b = wr_b + 1;
        end
        for (int c = 0; c < 10; c++) begin
            if_b.m_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            @(posedge clk);
            #1;
        end
        if_b.m_ready = 1'b1;
        rst = 1'b1;
        #1;
        chk("midrst_b_rdreq", 32'(if_b.rdreq), 32'd0);
        chk("midrst_b_valid", 32'(if_b.m_valid), 32'd0);
        chk("midrst_b_data", 32'(if_b.m_data), 32'd0);
        chk("midrst_b_cnt", 32'(cnt_b), 32'd0);
        chk("midrst_a_cnt", 32'(cnt_a), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_b_valid", 32'(if_b.m_valid), 32'd0);
        chk("post_rst_b_cnt", 32'(cnt_b), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
